// File: rtl/row_accumulator.sv
// Row dot-product stage: pops products from the upstream multiplier FIFO, sums ROW_LEN
// of them per row and queues the finished row sums in a small result FIFO.
module row_accumulator #(
    parameter int ROW_LEN   = 8,
    parameter int NUM_ROWS  = 8,
    parameter int ACC_W     = 24,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      mult_out,
    input  logic             mult_empty,
    output logic             mult_rd_en,
    input  logic             row_rd_en,
    output logic [ACC_W-1:0] row_out,
    output logic             row_empty,
    output logic             row_full,
    output logic             frame_done
);

    localparam int EW    = (ROW_LEN  > 1) ? $clog2(ROW_LEN)  : 1;
    localparam int RW    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int PW    = $clog2(OUT_DEPTH);
    localparam int CW    = PW + 1;
    localparam int OCC_W = CW + 1;

    localparam logic [EW-1:0]    LAST_ELEM = EW'(ROW_LEN - 1);
    localparam logic [RW-1:0]    LAST_ROW  = RW'(NUM_ROWS - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(OUT_DEPTH);
    localparam logic [CW-1:0]    DEPTH_CNT = CW'(OUT_DEPTH);

    // Issue-side state
    logic [EW-1:0]    elem_cnt_r;
    logic             in_vld_r;
    logic             in_first_r;
    logic             in_last_r;

    // Accumulation state
    logic [ACC_W-1:0] acc_r;
    logic [RW-1:0]    row_cnt_r;

    // Result FIFO state
    logic [ACC_W-1:0] mem_r [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    fifo_count_r;
    logic [ACC_W-1:0] row_out_r;
    logic             row_empty_r;
    logic             row_full_r;
    logic             frame_done_r;

    // Combinational helpers
    logic             is_last_s;
    logic             is_first_s;
    logic             pend_push_s;
    logic [OCC_W-1:0] occupancy_s;
    logic             space_s;
    logic             rd_en_s;
    logic [ACC_W-1:0] sum_s;
    logic             push_s;
    logic             pop_s;
    logic [CW-1:0]    count_next_s;
    logic             frame_end_s;

    // Read gating: the last element of a row is only issued when its sum has a FIFO slot,
    // counting a push that is still in flight from the previous issue.
    always_comb begin
        is_last_s   = (elem_cnt_r == LAST_ELEM);
        is_first_s  = (elem_cnt_r == {EW{1'b0}});
        pend_push_s = in_vld_r & in_last_r;
        occupancy_s = {1'b0, fifo_count_r} + {{CW{1'b0}}, pend_push_s};
        if (occupancy_s < DEPTH_OCC) begin
            space_s = 1'b1;
        end else begin
            space_s = 1'b0;
        end
        rd_en_s = ~rst & ~mult_empty & (~is_last_s | space_s);
    end

    // Datapath sum and FIFO control
    always_comb begin
        if (in_first_r) begin
            sum_s = {{(ACC_W-16){1'b0}}, mult_out};
        end else begin
            sum_s = acc_r + {{(ACC_W-16){1'b0}}, mult_out};
        end
        push_s      = pend_push_s & ~rst;
        pop_s       = row_rd_en & ~row_empty_r & ~rst;
        frame_end_s = push_s & (row_cnt_r == LAST_ROW);
        case ({push_s, pop_s})
            2'b10:   count_next_s = fifo_count_r + CW'(1);
            2'b01:   count_next_s = fifo_count_r - CW'(1);
            default: count_next_s = fifo_count_r;
        endcase
    end

    assign mult_rd_en = rd_en_s;

    // Element counter and one-cycle read-data qualifier pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_cnt_r <= {EW{1'b0}};
            in_vld_r   <= 1'b0;
            in_first_r <= 1'b0;
            in_last_r  <= 1'b0;
        end else begin
            in_vld_r <= rd_en_s;
            if (rd_en_s) begin
                in_first_r <= is_first_s;
                in_last_r  <= is_last_s;
                if (is_last_s) begin
                    elem_cnt_r <= {EW{1'b0}};
                end else begin
                    elem_cnt_r <= elem_cnt_r + EW'(1);
                end
            end
        end
    end

    // Running sum and row counter; a stall simply holds both
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= {ACC_W{1'b0}};
            row_cnt_r <= {RW{1'b0}};
        end else if (in_vld_r) begin
            if (in_last_r) begin
                acc_r <= {ACC_W{1'b0}};
                if (row_cnt_r == LAST_ROW) begin
                    row_cnt_r <= {RW{1'b0}};
                end else begin
                    row_cnt_r <= row_cnt_r + RW'(1);
                end
            end else begin
                acc_r <= sum_s;
            end
        end
    end

    // Result storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= sum_s;
        end
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
            row_empty_r  <= 1'b1;
            row_full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            fifo_count_r <= count_next_s;
            row_empty_r  <= (count_next_s == {CW{1'b0}});
            row_full_r   <= (count_next_s == DEPTH_CNT);
        end
    end

    // Registered read data and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            row_out_r    <= {ACC_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            if (pop_s) begin
                row_out_r <= mem_r[rd_ptr_r];
            end
            frame_done_r <= frame_end_s;
        end
    end

    assign row_out    = row_out_r;
    assign row_empty  = row_empty_r;
    assign row_full   = row_full_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator with a behavioural non-FWFT product source.
module tb_row_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mult_out = 16'h0000;
    logic        mult_empty;
    logic        mult_rd_en;
    logic        row_rd_en;
    logic [23:0] row_out;
    logic        row_empty;
    logic        row_full;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Product source: array with read/write indices, data valid the cycle after a pop
    logic [15:0] prod [0:127];
    int  wr_idx = 0;
    int  rd_idx = 0;
    logic stall = 1'b0;
    logic toggle_en = 1'b0;
    int  viol = 0;
    int  frame_cnt = 0;

    assign mult_empty = (rd_idx == wr_idx) || stall;

    row_accumulator #(
        .ROW_LEN(8), .NUM_ROWS(8), .ACC_W(24), .OUT_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .mult_out(mult_out), .mult_empty(mult_empty),
        .mult_rd_en(mult_rd_en), .row_rd_en(row_rd_en), .row_out(row_out),
        .row_empty(row_empty), .row_full(row_full), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mult_rd_en === 1'b1) begin
            mult_out <= prod[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    always @(posedge clk) begin
        if (toggle_en) stall <= ~stall;
        else           stall <= 1'b0;
    end

    always @(negedge clk) begin
        if (mult_rd_en === 1'b1 && mult_empty === 1'b1) viol++;
        if (frame_done === 1'b1) frame_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int n, input logic [15:0] v);
        for (int i = 0; i < n; i++) begin
            prod[wr_idx] = v;
            wr_idx = wr_idx + 1;
        end
    endtask

    task automatic wait_row(input string tag);
        int n;
        n = 0;
        while (row_empty !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, n < 300}, 32'd1);
    endtask

    task automatic pop_row;
        row_rd_en = 1'b1;
        @(negedge clk);
        row_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        row_rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prod[wr_idx] = 16'(i + 1);
            wr_idx = wr_idx + 1;
        end

        // 1: reset held with products available
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_rd_en", {31'd0, mult_rd_en}, 32'd0);
            check("rst_empty", {31'd0, row_empty}, 32'd1);
            check("rst_row_out", {8'd0, row_out}, 32'd0);
        end
        check("rst_full", {31'd0, row_full}, 32'd0);

        // 2: products 1..8 back to back, exact push latency
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("lat_still_empty", {31'd0, row_empty}, 32'd1);
        @(negedge clk);
        check("lat_not_empty", {31'd0, row_empty}, 32'd0);
        pop_row();
        check("row_1to8", {8'd0, row_out}, 32'd36);
        check("empty_after_pop", {31'd0, row_empty}, 32'd1);
        repeat (3) @(negedge clk);
        check("row_out_holds", {8'd0, row_out}, 32'd36);

        // 3: same stream with bubbles every other cycle
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prod[wr_idx] = 16'(i + 1);
            wr_idx = wr_idx + 1;
        end
        wait_row("bubble_timeout");
        toggle_en = 1'b0;
        pop_row();
        check("row_bubbles", {8'd0, row_out}, 32'd36);
        check("rd_while_empty", viol, 32'd0);

        // 4: fill the result FIFO, fifth row's last element must wait
        @(negedge clk);
        load(40, 16'd1);
        repeat (60) @(negedge clk);
        check("full_flag", {31'd0, row_full}, 32'd1);
        check("held_rd_en", {31'd0, mult_rd_en}, 32'd0);
        check("held_reads", rd_idx, 32'd55);
        pop_row();
        check("full_pop1", {8'd0, row_out}, 32'd8);
        for (int r = 0; r < 4; r++) begin
            wait_row("full_timeout");
            pop_row();
            check("full_popn", {8'd0, row_out}, 32'd8);
        end
        check("full_reads_done", rd_idx, 32'd56);
        check("no_frame_yet", frame_cnt, 32'd0);

        // 5: maximum products, eighth row closes the frame
        load(8, 16'hFFFF);
        wait_row("max_timeout");
        pop_row();
        check("row_max", {8'd0, row_out}, 32'h0007FFF8);
        repeat (5) @(negedge clk);
        check("frame_once", frame_cnt, 32'd1);

        // 6: reset mid-row drops the partial sum
        load(3, 16'd5);
        repeat (10) @(negedge clk);
        check("partial_reads", rd_idx, 32'd67);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_empty", {31'd0, row_empty}, 32'd1);
        check("mid_rst_row_out", {8'd0, row_out}, 32'd0);
        load(8, 16'd2);
        wait_row("post_rst_timeout");
        pop_row();
        check("row_after_rst", {8'd0, row_out}, 32'd16);
        repeat (20) @(negedge clk);
        check("single_row", {31'd0, row_empty}, 32'd1);
        check("frame_after_rst", frame_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
